store_check_monitor: RTL

- Synthesizable self-checking monitor for the processor data-memory write bus (`memwrite`, `dataadr`, `writedata`).
- Holds a programmable sequence of up to DEPTH expected stores and compares each observed store in order.
- Enforces a cycle timeout and reports pass/fail with a cause code, match count and the offending store.
- Sits beside `top` in simulation benches and FPGA bring-up, replacing ad-hoc `$stop` checkers.

---
 rtl/store_check_monitor_if.sv | 38 +++
 rtl/store_check_monitor.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/store_check_monitor_if.sv
// Bundle of the monitor's configuration, observed-store and status signals.
// The master side drives entries, start/clear and the store bus; the slave side is the monitor.
interface store_check_monitor_if #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          clear;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_data;
    logic          start;
    logic          memwrite;
    logic [AW-1:0] dataadr;
    logic [DW-1:0] writedata;
    logic          busy;
    logic          done;
    logic          pass;
    logic [1:0]    fail_code;
    logic [CW-1:0] match_count;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;

    modport master (
        output clear, cfg_valid, cfg_addr, cfg_data, start,
        output memwrite, dataadr, writedata,
        input  cfg_ready, busy, done, pass, fail_code, match_count, fail_addr, fail_data
    );

    modport slave (
        input  clear, cfg_valid, cfg_addr, cfg_data, start,
        input  memwrite, dataadr, writedata,
        output cfg_ready, busy, done, pass, fail_code, match_count, fail_addr, fail_data
    );
endinterface

// File: rtl/store_check_monitor.sv
// Compares observed data-memory stores against a loaded list of expected stores, in order.
// Define STORE_MON_FILTER_EN to skip stores whose address differs from the expected entry.
module store_check_monitor #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    store_check_monitor_if.slave  mon
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_PASS = 2'd2;
    localparam logic [1:0] S_FAIL = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] entries_q, entries_d;
    logic [CW-1:0] match_q, match_d;
    logic [TW-1:0] cyc_q, cyc_d;
    logic [1:0]    code_q, code_d;
    logic [AW-1:0] fail_addr_q, fail_addr_d;
    logic [DW-1:0] fail_data_q, fail_data_d;

    logic [AW-1:0] exp_addr_q [DEPTH];
    logic [DW-1:0] exp_data_q [DEPTH];

    logic          accept;
    logic          addr_hit;
    logic          data_hit;
    logic          terminal;
    logic [IW-1:0] idx;

    assign mon.cfg_ready = (state_q == S_LOAD) && (entries_q < DEPTH_C);
    assign accept        = mon.cfg_valid && mon.cfg_ready;

    // The match count doubles as the index of the next expected entry.
    assign idx      = match_q[IW-1:0];
    assign addr_hit = (mon.dataadr == exp_addr_q[idx]);
    assign data_hit = (mon.writedata == exp_data_q[idx]);

    always_ff @(posedge clk) begin
        if (accept && !mon.clear) begin
            exp_addr_q[entries_q[IW-1:0]] <= mon.cfg_addr;
            exp_data_q[entries_q[IW-1:0]] <= mon.cfg_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        entries_d   = entries_q;
        match_d     = match_q;
        cyc_d       = cyc_q;
        code_d      = code_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        terminal    = 1'b0;
        if (mon.clear) begin
            state_d     = S_LOAD;
            entries_d   = '0;
            match_d     = '0;
            cyc_d       = '0;
            code_d      = 2'd0;
            fail_addr_d = '0;
            fail_data_d = '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (accept) entries_d = entries_q + 1'b1;
                    if (mon.start) begin
                        if (entries_d == '0) begin
                            state_d = S_FAIL;
                            code_d  = 2'd3;
                        end else begin
                            state_d = S_RUN;
                            match_d = '0;
                            cyc_d   = '0;
                        end
                    end
                end
                S_RUN: begin
                    // An unknown strobe falls through to the no-store path.
                    if (mon.memwrite) begin
                        if (addr_hit && data_hit) begin
                            match_d = match_q + 1'b1;
                            if (match_d == entries_q) begin
                                state_d  = S_PASS;
                                terminal = 1'b1;
                            end
`ifdef STORE_MON_FILTER_EN
                        end else if (addr_hit) begin
`else
                        end else begin
`endif
                            state_d     = S_FAIL;
                            code_d      = 2'd1;
                            fail_addr_d = mon.dataadr;
                            fail_data_d = mon.writedata;
                            terminal    = 1'b1;
                        end
                    end
                    if (!terminal) begin
                        if (cyc_q == TO_LAST) begin
                            state_d = S_FAIL;
                            code_d  = 2'd2;
                        end else begin
                            cyc_d = cyc_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_LOAD;
            entries_q   <= '0;
            match_q     <= '0;
            cyc_q       <= '0;
            code_q      <= 2'd0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            state_q     <= state_d;
            entries_q   <= entries_d;
            match_q     <= match_d;
            cyc_q       <= cyc_d;
            code_q      <= code_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
        end
    end

    assign mon.busy        = (state_q == S_RUN);
    assign mon.done        = (state_q == S_PASS) || (state_q == S_FAIL);
    assign mon.pass        = (state_q == S_PASS);
    assign mon.fail_code   = code_q;
    assign mon.match_count = match_q;
    assign mon.fail_addr   = fail_addr_q;
    assign mon.fail_data   = fail_data_q;
endmodule
